// File: rtl/lcd_pkg.sv
// Shared types and constants for the character-LCD command/data sequencer.
package lcd_pkg;

   localparam int unsigned WORD_W     = 10;
   localparam int unsigned WORD_RS    = 9;
   localparam int unsigned WORD_RW    = 8;
   localparam int unsigned WORD_D_MSB = 7;
   localparam int unsigned WORD_D_LSB = 0;

   localparam logic [7:0] LCD_CLEAR     = 8'h01;
   localparam logic [7:0] LCD_HOME_MASK = 8'hFE;
   localparam logic [7:0] LCD_HOME_VAL  = 8'h02;

   typedef struct packed {
      logic       rs;
      logic       rw;
      logic [7:0] d;
   } lcd_word_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_SETUP,
      ST_E_HIGH,
      ST_HOLD,
      ST_NWAIT,
      ST_WAIT
   } state_t;

   // Clear display and return home need the long execution wait.
   function automatic logic is_long_cmd(input logic rs, input logic [7:0] d);
      return !rs && ((d == LCD_CLEAR) || ((d & LCD_HOME_MASK) == LCD_HOME_VAL));
   endfunction

endpackage

// File: rtl/lcd_sequencer_if.sv
// Command-memory, handshake and LCD pin bundle of the sequencer.
interface lcd_sequencer_if
   import lcd_pkg::*;
#(
   parameter int unsigned ADDR_W = 4
);
   logic              i_start;
   logic [ADDR_W-1:0] i_addr_begin;
   logic [ADDR_W-1:0] i_addr_end;
   logic [ADDR_W-1:0] o_addr;
   logic [WORD_W-1:0] i_word;
   logic              o_rs;
   logic              o_rw;
   logic [7:0]        o_db;
   logic              o_e;
   logic              o_busy;
   logic              o_done;

   modport master (
      input  i_start, i_addr_begin, i_addr_end, i_word,
      output o_addr, o_rs, o_rw, o_db, o_e, o_busy, o_done
   );

   modport slave (
      output i_start, i_addr_begin, i_addr_end, i_word,
      input  o_addr, o_rs, o_rw, o_db, o_e, o_busy, o_done
   );
endinterface

// File: rtl/lcd_wait_timer.sv
// Load-and-count-down timer; o_expire is high during the last of N loaded clocks.
module lcd_wait_timer #(
   parameter  int unsigned MAX_VALUE = 76500,
   localparam int unsigned W         = $clog2(MAX_VALUE + 1)
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_load,
   input  logic [W-1:0] i_value,
   output logic         o_expire
);

   logic [W-1:0] count;

   // Expire is precomputed one clock ahead so the owning state exits after exactly N clocks.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         count    <= '0;
         o_expire <= 1'b0;
      end else if (i_load) begin
         count    <= i_value;
         o_expire <= (i_value == W'(1));
      end else if (count != '0) begin
         count    <= count - W'(1);
         o_expire <= (count == W'(2));
      end else begin
         o_expire <= 1'b0;
      end
   end

endmodule

// File: rtl/lcd_sequencer.sv
// Walks a command-memory address range and issues each word to an HD44780-class
// LCD with setup, registered E pulse, hold and a per-command execution wait.
module lcd_sequencer
   import lcd_pkg::*;
#(
   parameter int unsigned ADDR_W      = 4,
   parameter int unsigned BUS_4BIT    = 0,
   parameter int unsigned E_CYCLES    = 12,
   parameter int unsigned NIBBLE_WAIT = 50,
   parameter int unsigned SHORT_WAIT  = 1850,
   parameter int unsigned LONG_WAIT   = 76500
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   lcd_sequencer_if.master bus
);

   localparam int unsigned TW          = $clog2(LONG_WAIT + 1);
   localparam bit          NIBBLE_MODE = (BUS_4BIT != 0);

   state_t            state;
   logic [ADDR_W-1:0] end_r;
   logic [7:0]        d_r;
   logic              second_r;

   logic              tmr_load_c;
   logic [TW-1:0]     tmr_value_c;
   logic              tmr_expire;

   lcd_word_t         word_c;
   logic              unused_rw_c;

   assign word_c      = bus.i_word;
   assign unused_rw_c = word_c.rw;

   // The busy flag is never read back, so the bus is write-only.
   assign bus.o_rw = 1'b0;

   lcd_wait_timer #(
      .MAX_VALUE (LONG_WAIT)
   ) u_timer (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_load   (tmr_load_c),
      .i_value  (tmr_value_c),
      .o_expire (tmr_expire)
   );

   // Timer is loaded on the edge that enters E_HIGH, NWAIT or WAIT.
   always_comb begin
      tmr_load_c  = 1'b0;
      tmr_value_c = '0;
      case (state)
         ST_SETUP: begin
            tmr_load_c  = 1'b1;
            tmr_value_c = TW'(E_CYCLES);
         end
         ST_HOLD: begin
            tmr_load_c = 1'b1;
            if (NIBBLE_MODE && !second_r)
               tmr_value_c = TW'(NIBBLE_WAIT);
            else if (is_long_cmd(bus.o_rs, d_r))
               tmr_value_c = TW'(LONG_WAIT);
            else
               tmr_value_c = TW'(SHORT_WAIT);
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state    <= ST_IDLE;
         end_r    <= '0;
         d_r      <= '0;
         second_r <= 1'b0;
         bus.o_addr <= '0;
         bus.o_rs   <= 1'b0;
         bus.o_db   <= '0;
         bus.o_e    <= 1'b0;
         bus.o_busy <= 1'b0;
         bus.o_done <= 1'b0;
      end else begin
         bus.o_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               // A start coinciding with the done pulse belongs to the finished run.
               if (bus.i_start && !bus.o_done) begin
                  end_r      <= bus.i_addr_end;
                  bus.o_addr <= bus.i_addr_begin;
                  bus.o_busy <= 1'b1;
                  state      <= ST_FETCH;
               end
            end
            ST_FETCH: begin
               d_r      <= word_c.d;
               second_r <= 1'b0;
               bus.o_rs <= word_c.rs;
               bus.o_db <= NIBBLE_MODE ? {word_c.d[7:4], 4'h0} : word_c.d;
               state    <= ST_SETUP;
            end
            ST_SETUP: begin
               bus.o_e <= 1'b1;
               state   <= ST_E_HIGH;
            end
            ST_E_HIGH: begin
               if (tmr_expire) begin
                  bus.o_e <= 1'b0;
                  state   <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (NIBBLE_MODE && !second_r) begin
                  second_r <= 1'b1;
                  state    <= ST_NWAIT;
               end else begin
                  state <= ST_WAIT;
               end
            end
            ST_NWAIT: begin
               if (tmr_expire) begin
                  bus.o_db <= {d_r[3:0], 4'h0};
                  state    <= ST_SETUP;
               end
            end
            ST_WAIT: begin
               if (tmr_expire) begin
                  if (bus.o_addr == end_r) begin
                     bus.o_done <= 1'b1;
                     bus.o_busy <= 1'b0;
                     state      <= ST_IDLE;
                  end else begin
                     bus.o_addr <= bus.o_addr + ADDR_W'(1);
                     state      <= ST_FETCH;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_sequencer.sv
// Scoreboard bench for lcd_sequencer: an 8-bit and a 4-bit instance share one command memory.
module tb_lcd_sequencer;

   localparam int unsigned ADDR_W = 4;
   localparam int unsigned E_CYC  = 2;
   localparam int unsigned NW     = 3;
   localparam int unsigned SW     = 5;
   localparam int unsigned LW     = 20;
   localparam int unsigned BUDGET = 2000;

   typedef struct packed {
      logic        is_done;
      logic [3:0]  addr;
      logic        rs;
      logic [7:0]  db;
      logic [15:0] gap;
   } ev_t;

   logic        clk = 1'b0;
   logic        rst_n;
   int unsigned cyc = 0;
   int          n_cmp = 0;
   int          n_bad = 0;

   logic [9:0]  mem [16];
   ev_t         exp_q [2][$];

   logic        start_s [2];
   logic [3:0]  begin_s [2];
   logic [3:0]  end_s   [2];

   logic [3:0]  addr_w [2];
   logic [7:0]  db_w   [2];
   logic        rs_w   [2];
   logic        rw_w   [2];
   logic        e_w    [2];
   logic        busy_w [2];
   logic        done_w [2];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_dut
      lcd_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

      lcd_sequencer #(
         .ADDR_W      (ADDR_W),
         .BUS_4BIT    (g),
         .E_CYCLES    (E_CYC),
         .NIBBLE_WAIT (NW),
         .SHORT_WAIT  (SW),
         .LONG_WAIT   (LW)
      ) u_dut (
         .i_clk   (clk),
         .i_rst_n (rst_n),
         .bus     (bus)
      );

      assign bus.i_start      = start_s[g];
      assign bus.i_addr_begin = begin_s[g];
      assign bus.i_addr_end   = end_s[g];
      assign bus.i_word       = mem[bus.o_addr];

      assign addr_w[g] = bus.o_addr;
      assign db_w[g]   = bus.o_db;
      assign rs_w[g]   = bus.o_rs;
      assign rw_w[g]   = bus.o_rw;
      assign e_w[g]    = bus.o_e;
      assign busy_w[g] = bus.o_busy;
      assign done_w[g] = bus.o_done;

      logic        prev_e;
      logic        prev_busy;
      logic        bad;
      int unsigned ref_cyc;
      int unsigned rise_cyc;
      ev_t         ev;

      // Gaps are measured from the start edge or the previous E fall.
      always @(negedge clk) begin
         if (!rst_n) begin
            prev_e    = 1'b0;
            prev_busy = 1'b0;
         end else begin
            if (bus.o_busy && !prev_busy) ref_cyc = cyc;
            if (bus.o_e && !prev_e) begin
               rise_cyc = cyc;
               bad = (exp_q[g].size() == 0) || exp_q[g][0].is_done;
               check($sformatf("dut%0d_e_expected", g), 32'(bad), 32'd0);
               if (!bad) begin
                  ev = exp_q[g].pop_front();
                  check($sformatf("dut%0d_addr", g), 32'(bus.o_addr), 32'(ev.addr));
                  check($sformatf("dut%0d_rs", g), 32'(bus.o_rs), 32'(ev.rs));
                  check($sformatf("dut%0d_db", g), 32'(bus.o_db), 32'(ev.db));
                  check($sformatf("dut%0d_rw", g), 32'(bus.o_rw), 32'd0);
                  check($sformatf("dut%0d_gap_to_e", g), cyc - ref_cyc, 32'(ev.gap));
               end
            end
            if (!bus.o_e && prev_e) begin
               check($sformatf("dut%0d_e_width", g), cyc - rise_cyc, E_CYC);
               ref_cyc = cyc;
            end
            if (bus.o_done) begin
               bad = (exp_q[g].size() == 0) || !exp_q[g][0].is_done;
               check($sformatf("dut%0d_done_expected", g), 32'(bad), 32'd0);
               if (!bad) begin
                  ev = exp_q[g].pop_front();
                  check($sformatf("dut%0d_gap_to_done", g), cyc - ref_cyc, 32'(ev.gap));
                  check($sformatf("dut%0d_done_addr", g), 32'(bus.o_addr), 32'(ev.addr));
                  check($sformatf("dut%0d_busy_at_done", g), 32'(bus.o_busy), 32'd0);
               end
            end
            prev_e    = bus.o_e;
            prev_busy = bus.o_busy;
         end
      end
   end

   // Expected E pulses and done for one run over begin..end (wrapping).
   task automatic push_seq(input int g, input logic [3:0] b, input logic [3:0] e);
      logic [3:0]  a;
      logic [9:0]  w;
      logic [7:0]  d;
      logic        rs;
      int unsigned wt;
      int unsigned gap;
      ev_t         ev;
      a   = b;
      gap = 2;
      wt  = 0;
      for (int k = 0; k < 16; k++) begin
         w  = mem[a];
         d  = w[7:0];
         rs = w[9];
         wt = (!rs && (d == 8'h01 || d[7:1] == 7'h01)) ? LW : SW;
         if (g == 0) begin
            ev = '{is_done: 1'b0, addr: a, rs: rs, db: d, gap: 16'(gap)};
            exp_q[g].push_back(ev);
         end else begin
            ev = '{is_done: 1'b0, addr: a, rs: rs, db: {d[7:4], 4'h0}, gap: 16'(gap)};
            exp_q[g].push_back(ev);
            ev = '{is_done: 1'b0, addr: a, rs: rs, db: {d[3:0], 4'h0}, gap: 16'(NW + 2)};
            exp_q[g].push_back(ev);
         end
         gap = wt + 3;
         if (a == e) break;
         a = a + 4'd1;
      end
      ev = '{is_done: 1'b1, addr: e, rs: 1'b0, db: 8'h00, gap: 16'(wt + 1)};
      exp_q[g].push_back(ev);
   endtask

   task automatic run_seq(input int g, input logic [3:0] b, input logic [3:0] e, input bit mid);
      int n;
      push_seq(g, b, e);
      @(negedge clk);
      begin_s[g] = b;
      end_s[g]   = e;
      start_s[g] = 1'b1;
      @(negedge clk);
      start_s[g] = 1'b0;
      if (mid) begin
         repeat (6) @(negedge clk);
         begin_s[g] = 4'd9;
         start_s[g] = 1'b1;
         @(negedge clk);
         start_s[g] = 1'b0;
         begin_s[g] = b;
      end
      n = 0;
      while (!done_w[g] && n < BUDGET) begin
         @(negedge clk);
         n++;
      end
      check($sformatf("dut%0d_done_seen", g), 32'(done_w[g]), 32'd1);
      // Start held through the done clock must not launch a new run.
      start_s[g] = 1'b1;
      @(negedge clk);
      start_s[g] = 1'b0;
      check($sformatf("dut%0d_no_restart_on_done", g), 32'(busy_w[g]), 32'd0);
      @(negedge clk);
      check($sformatf("dut%0d_queue_drained", g), 32'(exp_q[g].size()), 32'd0);
   endtask

   task automatic check_idle(input int g, input string tag);
      check($sformatf("dut%0d_%s_addr", g, tag), 32'(addr_w[g]), 32'd0);
      check($sformatf("dut%0d_%s_rs", g, tag), 32'(rs_w[g]), 32'd0);
      check($sformatf("dut%0d_%s_rw", g, tag), 32'(rw_w[g]), 32'd0);
      check($sformatf("dut%0d_%s_db", g, tag), 32'(db_w[g]), 32'd0);
      check($sformatf("dut%0d_%s_e", g, tag), 32'(e_w[g]), 32'd0);
      check($sformatf("dut%0d_%s_busy", g, tag), 32'(busy_w[g]), 32'd0);
      check($sformatf("dut%0d_%s_done", g, tag), 32'(done_w[g]), 32'd0);
   endtask

   initial begin
      int n;
      for (int i = 0; i < 16; i++) mem[i] = 10'h020;
      mem[0]  = 10'h001;
      mem[1]  = 10'h00C;
      mem[2]  = 10'h241;
      mem[3]  = 10'h038;
      mem[5]  = 10'h003;
      mem[6]  = 10'h004;
      mem[7]  = 10'h228;
      mem[8]  = 10'h101;
      mem[14] = 10'h248;
      mem[15] = 10'h002;
      for (int g = 0; g < 2; g++) begin
         start_s[g] = 1'b0;
         begin_s[g] = 4'd0;
         end_s[g]   = 4'd0;
      end
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check_idle(0, "reset");
      check_idle(1, "reset");
      #2 rst_n = 1'b1;

      run_seq(0, 4'd3, 4'd3, 1'b0);
      run_seq(0, 4'd0, 4'd2, 1'b1);
      run_seq(1, 4'd7, 4'd7, 1'b0);
      run_seq(0, 4'd14, 4'd1, 1'b0);
      run_seq(0, 4'd5, 4'd5, 1'b0);
      run_seq(0, 4'd6, 4'd6, 1'b0);
      run_seq(0, 4'd8, 4'd8, 1'b0);
      run_seq(1, 4'd0, 4'd2, 1'b0);
      run_seq(1, 4'd15, 4'd0, 1'b0);

      // Reset in the middle of an E pulse.
      push_seq(0, 4'd3, 4'd3);
      @(negedge clk);
      begin_s[0] = 4'd3;
      end_s[0]   = 4'd3;
      start_s[0] = 1'b1;
      @(negedge clk);
      start_s[0] = 1'b0;
      n = 0;
      while (!e_w[0] && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("dut0_rst_e_seen", 32'(e_w[0]), 32'd1);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("dut0_rst_async_e", 32'(e_w[0]), 32'd0);
      check("dut0_rst_async_busy", 32'(busy_w[0]), 32'd0);
      check("dut0_rst_async_addr", 32'(addr_w[0]), 32'd0);
      @(negedge clk);
      #2;
      exp_q[0].delete();
      rst_n = 1'b1;
      check_idle(0, "post_rst");
      run_seq(0, 4'd3, 4'd3, 1'b0);
      run_seq(1, 4'd2, 4'd3, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
